// File: rtl/csu_pkg.sv
// Shared widths and FSM state encoding for the range-scan compare/search unit.
package csu_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/range_addr_counter.sv
// Loadable read-address counter for an inclusive range; bounds are ordered on
// load and the counter saturates at the upper bound instead of wrapping.
module range_addr_counter #(
    parameter int unsigned ADDR_W = csu_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_bound_a,
    input  logic [ADDR_W-1:0] i_bound_b,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_at_end
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_end;
    logic              w_swap;
    logic              w_at_end;

    assign w_swap   = i_bound_a > i_bound_b;
    assign w_at_end = (r_addr == r_end);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr <= '0;
            r_end  <= '0;
        end else if (i_load) begin
            r_addr <= w_swap ? i_bound_b : i_bound_a;
            r_end  <= w_swap ? i_bound_a : i_bound_b;
        end else if (i_enable && !w_at_end) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr   = r_addr;
    assign o_at_end = w_at_end;

endmodule

// File: rtl/scan_range_csu.sv
// Scans an inclusive table address range for a key, reporting first hit address
// and hit count; optionally stops at the first hit.
module scan_range_csu import csu_pkg::*; #(
    parameter int unsigned ADDR_W = csu_pkg::ADDR_W,
    parameter int unsigned DATA_W = csu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DATA_W-1:0] key,
    input  logic              first_only,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [ADDR_W-1:0] hit_addr,
    output logic [ADDR_W:0]   hit_count
);

    state_e            r_state;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
    logic              r_hit;
    logic [ADDR_W-1:0] r_hit_addr;
    logic [ADDR_W:0]   r_hit_count;
    logic [DATA_W-1:0] r_key;
    logic              r_first_only;
    logic              r_cmp_valid;
    logic [ADDR_W-1:0] r_cmp_addr;

    logic              w_load;
    logic              w_enable;
    logic              w_match;
    logic              w_stop;
    logic              w_at_end;
    logic [ADDR_W-1:0] w_addr;

    assign w_load   = (r_state == StIdle) && start;
    assign w_match  = r_cmp_valid && (rd_data == r_key);
    assign w_stop   = w_match && r_first_only;
    assign w_enable = (r_state == StScan) && !w_stop;

    range_addr_counter #(
        .ADDR_W(ADDR_W)
    ) u_addr_cnt (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_load   (w_load),
        .i_enable (w_enable),
        .i_bound_a(start_addr),
        .i_bound_b(end_addr),
        .o_addr   (w_addr),
        .o_at_end (w_at_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_addr   <= '0;
            r_hit_count  <= '0;
            r_key        <= '0;
            r_first_only <= 1'b0;
            r_cmp_valid  <= 1'b0;
            r_cmp_addr   <= '0;
        end else begin
            // A first_only stop squashes the compare of the read already in flight.
            r_cmp_valid <= r_rd_en && !w_stop;
            r_cmp_addr  <= w_addr;
            if (w_match) begin
                r_hit       <= 1'b1;
                r_hit_count <= r_hit_count + 1'b1;
                if (!r_hit) begin
                    r_hit_addr <= r_cmp_addr;
                end
            end
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_key        <= key;
                        r_first_only <= first_only;
                        r_hit        <= 1'b0;
                        r_hit_addr   <= '0;
                        r_hit_count  <= '0;
                        r_rd_en      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= StScan;
                    end
                end
                StScan: begin
                    if (w_stop || w_at_end) begin
                        r_rd_en <= 1'b0;
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = w_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit       = r_hit;
    assign hit_addr  = r_hit_addr;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_scan_range_csu.sv
// Self-checking bench for scan_range_csu: directed scenarios plus randomized scans
// checked against a queue-based reference model of the scan rules.
module tb_scan_range_csu;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] start_addr;
    logic [4:0] end_addr;
    logic [7:0] key;
    logic       first_only;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       hit;
    logic [4:0] hit_addr;
    logic [5:0] hit_count;

    logic [7:0] mem [32];
    int checks;
    int failures;

    scan_range_csu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_addr(start_addr),
        .end_addr  (end_addr),
        .key       (key),
        .first_only(first_only),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .hit_addr  (hit_addr),
        .hit_count (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller must be at a negedge with the DUT idle.
    task automatic do_scan(input logic [4:0] sa, input logic [4:0] ea, input logic [7:0] k,
                           input logic fo, input string tag);
        int lo, hi, n, exp_cnt, exp_first, exp_done, c, done_c, busy_cyc, nchk;
        bit found;
        int exp_reads[$];
        int got_reads[$];
        logic [5:0] cnt_at_done;

        lo = (sa < ea) ? int'(sa) : int'(ea);
        hi = (sa < ea) ? int'(ea) : int'(sa);
        n = hi - lo + 1;
        found = 0;
        exp_cnt = 0;
        exp_first = 0;
        exp_done = n + 2;
        for (int a = lo; a <= hi; a++) begin
            exp_reads.push_back(a);
            if (mem[a[4:0]] == k) begin
                if (!found) exp_first = a;
                found = 1;
                exp_cnt++;
                if (fo) begin
                    if (a < hi) exp_reads.push_back(a + 1);
                    exp_done = (a - lo + 1) + 3;
                    if (exp_done > n + 2) exp_done = n + 2;
                    break;
                end
            end
        end

        start = 1'b1;
        start_addr = sa;
        end_addr = ea;
        key = k;
        first_only = fo;
        @(posedge clk);
        #1;
        // Scramble inputs to prove they were latched.
        start = 1'b0;
        start_addr = 5'($urandom);
        end_addr = 5'($urandom);
        key = 8'($urandom);
        first_only = 1'($urandom);

        done_c = 0;
        busy_cyc = 0;
        for (c = 1; c <= 60 && done_c == 0; c++) begin
            @(negedge clk);
            if (rd_en) got_reads.push_back(int'(rd_addr));
            if (busy) busy_cyc++;
            if (done) done_c = c;
        end

        chk({tag, "_done_cycle"}, done_c, exp_done);
        chk({tag, "_busy_cycles"}, busy_cyc, exp_done - 1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_num_reads"}, got_reads.size(), exp_reads.size());
        nchk = (got_reads.size() < exp_reads.size()) ? got_reads.size() : exp_reads.size();
        for (int i = 0; i < nchk; i++) chk({tag, "_read_addr"}, got_reads[i], exp_reads[i]);
        chk({tag, "_hit"}, hit, found);
        chk({tag, "_hit_addr"}, hit_addr, exp_first);
        chk({tag, "_hit_count"}, hit_count, exp_cnt);
        chk({tag, "_rd_addr_hold"}, rd_addr, exp_reads[exp_reads.size() - 1]);

        // A start presented during DONE must be ignored.
        cnt_at_done = hit_count;
        start = 1'b1;
        start_addr = 5'd0;
        end_addr = 5'd31;
        key = k;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_in_done_busy"}, busy, 1'b0);
        chk({tag, "_start_in_done_rden"}, rd_en, 1'b0);
        chk({tag, "_start_in_done_cnt"}, hit_count, cnt_at_done);
    endtask

    initial begin
        bit seen;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        end_addr = '0;
        key = '0;
        first_only = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rd_addr", rd_addr, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_hit_addr", hit_addr, 5'd0);
        chk("rst_hit_count", hit_count, 6'd0);
        reset = 1'b0;
        @(negedge clk);

        do_scan(5'd3, 5'd7, 8'd5, 1'b0, "basic");

        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_en) seen = 1;
        end
        chk("idle_rd_en", seen, 1'b0);
        chk("idle_hit", hit, 1'b1);
        chk("idle_hit_addr", hit_addr, 5'd5);
        chk("idle_hit_count", hit_count, 6'd1);

        for (int i = 0; i < 32; i++) mem[i] = 8'hAA;
        do_scan(5'd0, 5'd31, 8'hAA, 1'b0, "full");

        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        do_scan(5'd9, 5'd2, 8'd4, 1'b1, "swap_first");

        mem[12] = 8'h3C;
        do_scan(5'd12, 5'd12, 8'h3C, 1'b0, "single");

        // Busy start ignored, then reset mid-scan with no done pulse.
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        start = 1'b1;
        start_addr = 5'd0;
        end_addr = 5'd15;
        key = 8'hFF;
        first_only = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) seen = 1;
            if (c == 3) begin
                start = 1'b1;
                start_addr = 5'd20;
                end_addr = 5'd25;
                key = 8'd21;
            end
            if (c == 4) start = 1'b0;
            if (c == 5) begin
                chk("busy_start_rd_addr", rd_addr, 5'd4);
                chk("busy_start_busy", busy, 1'b1);
            end
            if (c == 7) reset = 1'b1;
        end
        @(negedge clk);
        if (done) seen = 1;
        chk("abort_no_done", seen, 1'b0);
        chk("abort_rd_en", rd_en, 1'b0);
        chk("abort_rd_addr", rd_addr, 5'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_hit", hit, 1'b0);
        chk("abort_hit_addr", hit_addr, 5'd0);
        chk("abort_hit_count", hit_count, 6'd0);
        reset = 1'b0;
        do_scan(5'd2, 5'd4, 8'd3, 1'b0, "after_reset");

        // Reset dominates a simultaneous start.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        start_addr = 5'd1;
        end_addr = 5'd5;
        @(negedge clk);
        chk("rst_dom_busy", busy, 1'b0);
        chk("rst_dom_rd_en", rd_en, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_dom_idle", busy, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 7));
            do_scan(5'($urandom), 5'($urandom), 8'($urandom_range(0, 8)), 1'($urandom), "rnd");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_range_csu.md
SCAN_RANGE_CSU -- requirements
Module: scan_range_csu

Interface
REQ-001 Parameter ADDR_W, default 5, address width of the scanned table (32 entries).
REQ-002 Parameter DATA_W, default 8, width of table word and search key.
REQ-003 Single clock `clk`; reset `reset` is synchronous and active-high; both stated exactly so here and fixed.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
REQ-007 start_addr  in  ADDR_W  first address of range (upstream ordered "start" output).
REQ-008 end_addr  in  ADDR_W  last address of range, inclusive (upstream ordered "end" output).
REQ-009 key  in  DATA_W  value searched for.
REQ-010 first_only  in  1  1 = stop at first hit; 0 = scan full range and count hits.
REQ-011 rd_en  out  1  table read strobe.
REQ-012 rd_addr  out  ADDR_W  table read address.
REQ-013 rd_data  in  DATA_W  table word, valid the cycle after rd_en.
REQ-014 busy  out  1  scan in progress.
REQ-015 done  out  1  one-cycle pulse at scan end.
REQ-016 hit  out  1  at least one match found in last scan.
REQ-017 hit_addr  out  ADDR_W  lowest matching address of last scan.
REQ-018 hit_count  out  ADDR_W+1  number of matches in last scan (0..32).

Function
REQ-019 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after issuing end address or on first_only hit; DRAIN->DONE; DONE->IDLE unconditionally.
REQ-020 On accepted start (edge E0), start_addr, end_addr, key, first_only SHALL be latched; hit, hit_addr, hit_count cleared.
REQ-021 If latched start_addr > end_addr the block SHALL swap them; range is always min..max inclusive.
REQ-022 In SCAN, rd_en=1 every cycle; rd_addr = start in cycle 1, incrementing by 1 per cycle, reaching end in cycle N (N = end-start+1).
REQ-023 The address counter SHALL never wrap: range 0..31 issues exactly 32 reads and terminates.
REQ-024 rd_data SHALL be compared to key the cycle after each read, tagged with the delayed address.
REQ-025 On match: hit=1, hit_count+=1, hit_addr set only on first match of the scan.
REQ-026 first_only=1, match of read issued in cycle k: no reads after cycle k+1; the read in k+1 (if any) SHALL be ignored; done in cycle k+3.
REQ-027 Full scan timing: busy high cycles 1..N+1, done high in cycle N+2 only, busy low during done.
REQ-028 start==end (upstream "same"): exactly one read, done in cycle 3.
REQ-029 start while busy or in DONE SHALL be ignored, no latching.
REQ-030 hit, hit_addr, hit_count SHALL hold after done until the next accepted start.
REQ-031 rd_en=0 in IDLE, DRAIN, DONE; rd_addr holds its last value.

Reset
REQ-032 reset SHALL force IDLE and rd_en=0, rd_addr=0, busy=0, done=0, hit=0, hit_addr=0, hit_count=0.
REQ-033 reset mid-scan SHALL abort without a done pulse; a start in the cycle after reset release SHALL be accepted.
REQ-034 reset dominates start in the same cycle.

Structure
REQ-035 Package csu_pkg SHALL hold ADDR_W, DATA_W, CNT_W (=ADDR_W+1) and the FSM state encoding.
REQ-036 One sub-module range_addr_counter (load, enable, terminal-at-end flag) SHALL generate rd_addr; compare and FSM stay in the top.

Verification
REQ-037 Table[i]=i; start=3,end=7,key=5,first_only=0 -> reads 3..7 cycles 1..5, hit=1, hit_addr=5, hit_count=1, done cycle 7.
REQ-038 Table all 0xAA; start=0,end=31,key=0xAA,first_only=0 -> 32 reads, no wrap, hit_count=32, hit_addr=0, done cycle 34.
REQ-039 Table[i]=i; start=9,end=2 (swapped),key=4,first_only=1 -> reads 2,3,4,5; hit_addr=4, hit_count=1, done cycle 6.
REQ-040 start=end=12, Table[12]=0x3C, key=0x3C -> one read, hit=1, hit_addr=12, done cycle 3.
REQ-041 key absent, range 0..15; second start in cycle 4; reset in cycle 8 -> second start ignored, no done, all outputs 0 cycle 9.
REQ-042 After REQ-037 scan, hold 10 idle cycles -> hit/hit_addr/hit_count unchanged, rd_en=0.
